iccm_boot_loader: RTL and testbench



---
 rtl/rv32i_x_pkg.sv | 19 +
 rtl/ldr_word_asm.sv | 42 ++++
 rtl/iccm_boot_loader.sv | 152 +++++++++++++++
 tb/tb_iccm_boot_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_x_pkg.sv
// Shared loader definitions: state encoding and ICCM word geometry.
// Imported by the boot loader and its word assembler.
package rv32i_x_pkg;

  localparam int unsigned ICCM_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LDR_LEN  = 3'd0,
    LDR_DATA = 3'd1,
    LDR_CHK  = 3'd2,
    LDR_DONE = 3'd3,
    LDR_ERR  = 3'd4
  } ldr_state_e;

  function automatic logic ldr_rx_open(input ldr_state_e s);
    return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CHK);
  endfunction

endpackage

// File: rtl/ldr_word_asm.sv
// Little-endian byte-to-word assembler shared by the length field
// and the image data words.
module ldr_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] sr_q, sr_d;

  always_comb begin
    sr_d   = sr_q;
    bidx_d = bidx_q;
    if (byte_vld) begin
      sr_d   = {byte_in, sr_q[31:8]};
      bidx_d = bidx_q + 2'd1;
    end
    // A state change restarts word framing at byte 0.
    if (clr) begin
      bidx_d = 2'd0;
    end
  end

  assign word       = {byte_in, sr_q[31:8]};
  assign word_ready = byte_vld && (bidx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bidx_q <= 2'd0;
      sr_q   <= 32'd0;
    end else begin
      bidx_q <= bidx_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/iccm_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed image into the ICCM
// and holds the core in reset until the image is verified.
module iccm_boot_loader
  import rv32i_x_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             iccm_wr_en,
  output logic [31:0]      iccm_wr_addr,
  output logic [31:0]      iccm_wr_data,
  output logic             core_rst_n,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  ldr_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]       csum_q, csum_d;
  logic             rdy_q, rdy_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             crst_q, crst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             clr;
  logic [31:0]      word;
  logic             word_ready;

  assign accept = rx_valid && rdy_q;
  assign clr    = (state_d != state_q);

  ldr_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .byte_vld   (accept),
    .byte_in    (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      LDR_LEN: begin
        wcnt_d = '0;
        csum_d = 8'd0;
        if (word_ready) begin
          len_d = word[CNT_W-1:0];
          if (word > MAX_WORDS) begin
            state_d = LDR_ERR;
          end else if (word == 32'd0) begin
            state_d = LDR_CHK;
          end else begin
            state_d = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
        end
        if (word_ready) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_BASE + 32'(wcnt_q) * ICCM_WORD_BYTES;
          data_d  = word;
          wcnt_d  = wcnt_q + CNT_W'(1);
          if (wcnt_q + CNT_W'(1) == len_q) begin
            state_d = LDR_CHK;
          end
        end
      end
      LDR_CHK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? LDR_DONE : LDR_ERR;
        end
      end
      LDR_DONE, LDR_ERR: begin
        if (start) begin
          state_d = LDR_LEN;
          wcnt_d  = '0;
        end
      end
      default: state_d = LDR_LEN;
    endcase
  end

  // Status flags follow the settled state; start clears them at once.
  always_comb begin
    done_d = (state_q == LDR_DONE) && !start;
    err_d  = (state_q == LDR_ERR) && !start;
    crst_d = done_d;
    rdy_d  = ldr_rx_open(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LDR_LEN;
      len_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= 8'd0;
      rdy_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= ADDR_BASE;
      data_q  <= 32'd0;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      rdy_q   <= rdy_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_ready     = rdy_q;
  assign iccm_wr_en   = wr_en_q;
  assign iccm_wr_addr = addr_q;
  assign iccm_wr_data = data_q;
  assign core_rst_n   = crst_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Scoreboard bench for the ICCM boot loader: directed and random
// images checked against a byte-stream reference model.
module tb_iccm_boot_loader;

  localparam logic [31:0] ADDR_BASE = 32'h0000_0100;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned CNT_W     = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             iccm_wr_en;
  logic [31:0]      iccm_wr_addr;
  logic [31:0]      iccm_wr_data;
  logic             core_rst_n;
  logic             load_done;
  logic             load_err;
  logic [CNT_W-1:0] words_loaded;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          start_at = -1;

  iccm_boot_loader #(
    .ADDR_BASE (ADDR_BASE),
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .iccm_wr_en   (iccm_wr_en),
    .iccm_wr_addr (iccm_wr_addr),
    .iccm_wr_data (iccm_wr_data),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every ICCM write must match the next expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && iccm_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr %h data %h, none expected",
                 iccm_wr_addr, iccm_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (iccm_wr_addr !== mon_e.a || iccm_wr_data !== mon_e.d) begin
          bad++;
          $display("FAIL write: got %h@%h want %h@%h",
                   iccm_wr_data, iccm_wr_addr, mon_e.d, mon_e.a);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gaps,
                           input bit st);
    repeat (gaps) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    if (rx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL rx_ready_low: got %b want 1", rx_ready);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = 8'd0;
    for (int w = 0; w < n; w++) begin
      logic [31:0] v = img[w];
      x = x ^ v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    end
    return x;
  endfunction

  task automatic wait_end(output bit seen);
    int n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      if (load_done === 1'b1 || load_err === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  // gmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic run_load(input string tag, input logic [31:0] len,
                          input logic [7:0] chk, input int gmode);
    logic [7:0] bs[$];
    bit ok, exp_done, seen;
    int nw, gaps;
    wr_t e;
    ok = (len <= MAX_WORDS);
    nw = ok ? int'(len) : 0;
    for (int i = 0; i < 4; i++) bs.push_back(len[8*i +: 8]);
    if (ok) begin
      for (int w = 0; w < nw; w++) begin
        logic [31:0] v = img[w];
        e.a = ADDR_BASE + 32'(4 * w);
        e.d = v;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) bs.push_back(v[8*i +: 8]);
      end
      bs.push_back(chk);
    end
    exp_done = ok && (chk == img_xor(nw));
    for (int k = 0; k < bs.size(); k++) begin
      gaps = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(bs[k], gaps, k == start_at);
    end
    wait_end(seen);
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done/err after stream", tag);
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"}, 32'(load_err), 32'(!exp_done));
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
    check({tag, "_words"}, 32'(words_loaded), 32'(nw));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    start_at = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_core_rst_n", 32'(core_rst_n), 32'd0);
    check("restart_done", 32'(load_done), 32'd0);
    check("restart_err", 32'(load_err), 32'd0);
    check("restart_words", 32'(words_loaded), 32'd0);
    check("restart_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"}, 32'(iccm_wr_en), 32'd0);
    check({tag, "_wr_addr"}, iccm_wr_addr, ADDR_BASE);
    check({tag, "_wr_data"}, iccm_wr_data, 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] len;
    logic [7:0]  chk;
    wr_t         e;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    check("rx_ready_first", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rx_ready_second", 32'(rx_ready), 32'd1);

    img = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_load("nominal", 32'd2, img_xor(2), 0);
    pulse_start();
    run_load("badchk", 32'd2, img_xor(2) ^ 8'h01, 0);
    pulse_start();
    run_load("oversize", MAX_WORDS + 1, 8'h00, 0);
    pulse_start();
    img.delete();
    run_load("zero", 32'd0, 8'h00, 0);
    pulse_start();
    img = '{32'h0102_0304, 32'hA5A5_5A5A, 32'hFFFF_0000};
    run_load("gapped", 32'd3, img_xor(3), 1);
    pulse_start();
    img = '{32'hCAFE_F00D};
    run_load("restart", 32'd1, img_xor(1), 0);
    pulse_start();
    img = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    start_at = 6;
    run_load("start_ignored", 32'd3, img_xor(3), 0);
    pulse_start();
    img.delete();
    for (int w = 0; w < int'(MAX_WORDS); w++) img.push_back($urandom);
    run_load("max_len", MAX_WORDS, img_xor(int'(MAX_WORDS)), 2);

    for (int it = 0; it < 10; it++) begin
      int r;
      pulse_start();
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 32'd0;
      else if (r == 1) len = MAX_WORDS + 1 + $urandom_range(0, 1000);
      else len = 32'($urandom_range(1, 6));
      img.delete();
      if (len <= MAX_WORDS)
        for (int w = 0; w < int'(len); w++) img.push_back($urandom);
      chk = (len <= MAX_WORDS) ? img_xor(int'(len)) : 8'h00;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      start_at = int'($urandom_range(0, 12));
      run_load("random", len, chk, 2);
    end

    // Reset after two bytes of word 1: only word 0 may reach the ICCM.
    pulse_start();
    img = '{32'h0BAD_F00D, 32'h7777_8888};
    e.a = ADDR_BASE;
    e.d = img[0];
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 2 : 0), 0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(img[0][8*i +: 8], 0, 1'b0);
    send_byte(8'h88, 0, 1'b0);
    send_byte(8'h88, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    img = '{32'h7777_8888};
    run_load("after_reset", 32'd1, img_xor(1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
